// File: rtl/lcd_bus_pkg.sv
// lcd_bus_pkg: shared LCD bus field indices, command codes, DDRAM address map and event record
package lcd_bus_pkg;
  localparam int BIT_RS = 8;
  localparam int BIT_RW = 9;
  localparam int BIT_EN = 10;
  localparam int BIT_ON = 11;
  localparam int BIT_BLON = 12;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [6:0] CMD_HOME = 7'h01;
  localparam logic [5:0] CMD_ENTRY = 6'h01;
  localparam int CMD_SET_DDRAM = 7;
  localparam logic [6:0] ADDR_HOME = 7'h00;
  localparam logic [6:0] LINE0_END = 7'h27;
  localparam logic [6:0] LINE1_START = 7'h40;
  localparam logic [6:0] LINE1_END = 7'h67;
  typedef struct packed {
    logic rs;
    logic [6:0] addr;
    logic [7:0] data;
  } lcd_evt_t;
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    return inc ? (a == LINE0_END ? LINE1_START : a == LINE1_END ? ADDR_HOME : a + 7'd1)
               : (a == LINE1_START ? LINE0_END : a == ADDR_HOME ? LINE1_END : a - 7'd1);
  endfunction
endpackage

// File: rtl/lcd_evt_fifo.sv
// lcd_evt_fifo: first-word-fall-through event queue that drops pushes when full
module lcd_evt_fifo #(
  parameter int W = 16,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic [W-1:0] din,
  output logic valid,
  output logic [W-1:0] dout,
  output logic drop
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, do_push, do_pop;
  assign valid = wr_ptr != rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign do_pop = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign drop = push & ~do_push;
  assign dout = valid ? mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: decodes LCD PIO write strobes into queued events with DDRAM address tracking and sticky protocol errors
module lcd_bus_decoder
  import lcd_bus_pkg::*;
#(
  parameter int MIN_EN_HIGH = 12,
  parameter int BUSY_SHORT = 2000,
  parameter int BUSY_LONG = 76000,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk_clk,
  input logic reset_reset,
  input logic [12:0] lcd_bus,
  output logic evt_valid,
  input logic evt_ready,
  output logic [15:0] evt_data,
  output logic [6:0] ddram_addr,
  output logic lcd_on,
  output logic lcd_blon,
  output logic err_overflow,
  output logic err_glitch,
  output logic err_busy,
  input logic err_clear
);
  localparam int CW = $clog2(MIN_EN_HIGH + 1);
  localparam int BW = $clog2(BUSY_LONG + 1);
  logic [12:0] s1;
  logic [10:0] s2;
  logic [CW-1:0] en_cnt;
  logic [BW-1:0] busy_cnt;
  logic id, fall, strobe_ok, wr, rs, is_clear, is_home, is_entry, long_cmd, push_q, drop;
  logic [7:0] d;
  logic [6:0] addr_nxt;
  lcd_evt_t evt_q;
  assign rs = s2[BIT_RS];
  assign d = s2[7:0];
  assign fall = s2[BIT_EN] & ~s1[BIT_EN];
  assign strobe_ok = en_cnt == CW'(MIN_EN_HIGH);
  assign wr = fall & strobe_ok & ~s2[BIT_RW];
  assign is_clear = ~rs & (d == CMD_CLEAR);
  assign is_home = ~rs & (d[7:1] == CMD_HOME);
  assign is_entry = ~rs & (d[7:2] == CMD_ENTRY);
  assign long_cmd = is_clear | is_home;
  assign addr_nxt = rs ? step_addr(ddram_addr, id) : d[CMD_SET_DDRAM] ? d[6:0] : long_cmd ? ADDR_HOME : ddram_addr;
  assign lcd_on = s1[BIT_ON];
  assign lcd_blon = s1[BIT_BLON];
  always_ff @(posedge clk_clk or posedge reset_reset)
    if (reset_reset) begin
      s1 <= '0;
      s2 <= '0;
      en_cnt <= '0;
      busy_cnt <= '0;
      ddram_addr <= ADDR_HOME;
      id <= 1'b1;
      push_q <= 1'b0;
      evt_q <= '0;
      err_overflow <= 1'b0;
      err_glitch <= 1'b0;
      err_busy <= 1'b0;
    end else begin
      s1 <= lcd_bus;
      s2 <= s1[10:0];
      en_cnt <= !s1[BIT_EN] ? '0 : strobe_ok ? en_cnt : en_cnt + 1'b1;
      busy_cnt <= wr ? (long_cmd ? BW'(BUSY_LONG) : BW'(BUSY_SHORT)) : busy_cnt != '0 ? busy_cnt - 1'b1 : busy_cnt;
      ddram_addr <= wr ? addr_nxt : ddram_addr;
      id <= wr & is_clear ? 1'b1 : wr & is_entry ? d[1] : id;
      push_q <= wr;
      evt_q <= '{rs: rs, addr: ddram_addr, data: d};
      err_overflow <= drop | (err_overflow & ~err_clear);
      err_glitch <= (fall & ~strobe_ok) | (err_glitch & ~err_clear);
      err_busy <= (wr & (busy_cnt != '0)) | (err_busy & ~err_clear);
    end
  lcd_evt_fifo #(.W($bits(lcd_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_clk),
    .rst(reset_reset),
    .push(push_q),
    .pop(evt_ready),
    .din(evt_q),
    .valid(evt_valid),
    .dout(evt_data),
    .drop(drop)
  );
endmodule

// File: doc/lcd_bus_decoder.md
LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 Parameter MIN_EN_HIGH, default 12: minimum EN-high cycles for a strobe to count as valid (240 ns at 50 MHz).
REQ-002 Parameter BUSY_SHORT, default 2000: busy window in cycles after a normal command or data write (40 us).
REQ-003 Parameter BUSY_LONG, default 76000: busy window in cycles after a clear or return-home command (1.52 ms).
REQ-004 Parameter FIFO_DEPTH, default 4: number of event FIFO entries; must be a power of two.
REQ-005 clk_clk  in  1  single system clock; all logic is on the rising edge.
REQ-006 reset_reset  in  1  asynchronous, active-high reset.
REQ-007 lcd_bus  in  13  LCD PIO export: [7:0] DATA, [8] RS, [9] RW, [10] EN, [11] ON, [12] BLON.
REQ-008 evt_valid  out  1  event FIFO is non-empty.
REQ-009 evt_ready  in  1  consumer accepts the head event.
REQ-010 evt_data  out  16  head event, packed as {RS, DDRAM address before the write [6:0], DATA[7:0]}.
REQ-011 ddram_addr  out  7  current tracked DDRAM address.
REQ-012 lcd_on, lcd_blon  out  1 each  registered copies of ON and BLON.
REQ-013 err_overflow, err_glitch, err_busy  out  1 each  sticky error flags.
REQ-014 err_clear  in  1  one-cycle pulse that clears all sticky error flags.

Function
REQ-015 lcd_bus SHALL be registered twice (s1, s2); a strobe edge SHALL be detected when s2.EN=1 and s1.EN=0.
REQ-016 An EN-high counter SHALL count cycles with s1.EN=1 and saturate at MIN_EN_HIGH.
REQ-017 A falling edge with count < MIN_EN_HIGH SHALL set err_glitch and SHALL be discarded.
REQ-018 A valid falling edge with RW=1 SHALL be ignored: no event, no address change, no busy check.
REQ-019 A valid falling edge with RW=0 SHALL push one event, using RS and DATA as held in s2.
REQ-020 With an empty FIFO, evt_valid SHALL rise exactly 2 cycles after the first clock edge that samples EN=0.
REQ-021 Handshake: the head is popped on a cycle with evt_valid and evt_ready; evt_data SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-022 A push into a full FIFO without a pop SHALL drop the new event and set err_overflow.
REQ-023 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full.
REQ-024 RS=1 (data write): the address SHALL step by +1 if I/D=1, or -1 if I/D=0.
REQ-025 Address wrap SHALL be 0x27->0x40, 0x67->0x00, 0x40->0x27 (decrement) and 0x00->0x67 (decrement).
REQ-026 RS=0, DATA=0x01 (clear): address SHALL become 0x00 and I/D SHALL become 1; the busy window is BUSY_LONG.
REQ-027 RS=0, DATA=0x02 or 0x03 (home): address SHALL become 0x00; the busy window is BUSY_LONG.
REQ-028 RS=0, DATA=0x04..0x07 (entry mode): I/D SHALL take DATA[1].
REQ-029 RS=0, DATA[7]=1 (set DDRAM address): the address SHALL take DATA[6:0].
REQ-030 A set-address value in 0x28..0x3F or 0x68..0x7F SHALL be stored as given, and wrap SHALL then apply modulo 128.
REQ-031 All other commands SHALL be recorded as events with no effect on the address.
REQ-032 A busy down-counter SHALL load BUSY_LONG or BUSY_SHORT on each RW=0 event.
REQ-033 An RW=0 event arriving while the busy counter is non-zero SHALL set err_busy; the event is still recorded and the counter reloads.
REQ-034 err_clear SHALL clear all flags; an error arising in the same cycle SHALL win and the flag stays set.
REQ-035 lcd_on and lcd_blon SHALL follow s1.ON and s1.BLON continuously.

Reset
REQ-036 Reset SHALL empty the FIFO and drive evt_valid=0 and evt_data=0.
REQ-037 Reset SHALL set ddram_addr=0 and I/D=1.
REQ-038 Reset SHALL clear the busy counter, the EN-high counter, s1/s2, all error flags, lcd_on and lcd_blon.
REQ-039 A reset asserted mid-strobe SHALL cancel the strobe; the first EN falling edge after reset release SHALL be discarded unless EN was high for MIN_EN_HIGH cycles after release.

Structure
REQ-040 Package lcd_bus_pkg SHALL hold the bus bit-index constants, command codes, address wrap constants and the event record type.
REQ-041 The event FIFO SHALL be a separate sub-module, lcd_evt_fifo, with parameterized width and depth.

Verification
REQ-042 Bench SHALL run: entry mode 0x06, set address 0xA7 (address 0x27), write data 'A' -> event {1,0x27,0x41}, then ddram_addr=0x40.
REQ-043 Bench SHALL run: EN high for 5 cycles, then fall -> err_glitch=1, no event, address unchanged.
REQ-044 Bench SHALL run: evt_ready=0 and 5 valid writes -> 4 events retained, err_overflow=1; drained events are in order.
REQ-045 Bench SHALL run: clear 0x01 then a data write 1000 cycles later -> err_busy=1; the event has address 0x00.
REQ-046 Bench SHALL run: entry mode 0x04 at address 0x00, then write -> ddram_addr=0x67; RW=1 strobe -> no event.
REQ-047 Bench SHALL run: reset asserted while 2 events are queued -> evt_valid=0 on the next cycle, ddram_addr=0, all flags=0.
